spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Synthesizable, parametrised SPI master. Runs one transfer of WIDTH bits, MSB first, in any of the four CPOL/CPHA modes.
- Drives one of NSS active-low slave selects, with a programmable SCLK rate.
- Sits between the board-level controller logic and external SPI slaves, including our CPLD slave (main).
- Its timing is fixed in hardware, so it replaces hand-sequenced bench tasks as the bus driver on FPGA-side designs.

Parameters:
- WIDTH, 8: bits per transfer (2..32).
- HALF_DIV, 2: clk cycles per SCLK half-period (>=1).
- NSS, 1: number of slave-select outputs (1..8).
- SEL_W, 1: width of ss_sel (must satisfy 2^SEL_W >= NSS).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_l  in  1  synchronous, active-low reset, sampled on posedge clk.
- start  in  1  transfer request; sampled only while idle.
- cpol  in  1  SCLK idle level; captured when start is accepted.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; captured when start is accepted.
- ss_sel  in  SEL_W  index of the target slave; captured when start is accepted.
- tx_data  in  WIDTH  word to send; captured when start is accepted.
- miso  in  1  serial data from the slave.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data to the slave.
- ss_l  out  NSS  active-low slave selects; at most one bit is low at any time.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- rx_data  out  WIDTH  last received word; held between transfers.

Behaviour:

Reset (rst_l low at posedge):
- Next cycle: state IDLE, sclk=0, mosi=0, ss_l all ones, busy=0, done=0, rx_data=0.
- Reset during a transfer aborts it immediately. No done pulse; rx_data is cleared.

FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - start=1 and ss_sel<NSS: capture cpol/cpha/ss_sel/tx_data, go to SETUP.
  - ss_sel>=NSS: start is ignored (no busy, no done).
  - sclk drives the captured cpol (reset value 0).
- SETUP: lasts HALF_DIV cycles.
  - ss_l[ss_sel]=0 from the first SETUP cycle.
  - sclk=cpol.
  - cpha=0: mosi = tx_data MSB from the first SETUP cycle.
- SHIFT: lasts 2*WIDTH*HALF_DIV cycles.
  - sclk toggles every HALF_DIV cycles, giving 2*WIDTH edges. Edge k (1-based): odd k = leading, even k = trailing.
  - cpha=0: sample miso on leading edges; shift mosi to the next bit on trailing edges. No mosi change after the final edge.
  - cpha=1: shift mosi on leading edges (MSB placed on edge 1); sample miso on trailing edges.
  - Receive shift register fills MSB first.
- HOLD: lasts HALF_DIV cycles.
  - sclk=cpol; ss_l stays asserted.
  - At the end of HOLD: ss_l returns to all ones, rx_data is loaded, go to IDLE.
- After HOLD: done=1 for exactly one cycle, the first IDLE cycle.

Handshake and timing:
- busy rises the cycle after start is accepted and stays high for exactly HALF_DIV*(2*WIDTH+2) cycles.
- start while busy=1 is ignored. Transfers are never queued.
- start may be held high on the done cycle; a new transfer is then accepted that cycle. Back-to-back transfers therefore have exactly one IDLE cycle, with ss_l high, between them.
- tx_data, cpol, cpha and ss_sel may change freely while busy; they have no effect until the next accepted start.
- miso is sampled directly; synchronisation is the integrator's responsibility.

Counters:
- Divide counter: range 0..HALF_DIV-1, wraps.
- Edge counter: range 0..2*WIDTH, compared at wrap.
- Both cleared on every state entry.

Test Plan:
- Basic mode 0: WIDTH=8, HALF_DIV=2, cpol=0, cpha=0, tx=0xF4, miso looped to mosi.
  - 16 sclk edges; mosi bits 1,1,1,1,0,1,0,0 stable at each rising edge.
  - busy high 36 cycles; done pulses once; rx_data=0xF4; ss_l[0] low for 36 cycles.
- Mode 3: cpol=1, cpha=1; slave model drives 0x7F MSB-first on falling edges.
  - sclk idles 1; rx_data=0x7F.
  - mosi changes only on falling edges.
- Multiple selects: WIDTH=16, NSS=4, ss_sel=2, tx=0xA5C3.
  - Only ss_l[2] goes low.
  - 32 edges; rx_data equals the slave word 0x1234.
  - ss_sel=5 with start: ignored, busy stays 0.
- Handshake: pulse start again mid-transfer, which is ignored. Then hold start high across done.
  - Second transfer begins with exactly one ss_l-high cycle between transfers.
  - Exactly two done pulses in total.
- Reset abort: assert rst_l=0 at edge 7 of a transfer.
  - Next cycle: ss_l=all ones, sclk=0, busy=0, rx_data=0, no done.
  - Next start runs a normal transfer.
- Divider extreme: HALF_DIV=1.
  - sclk period = 2 clk cycles.
  - busy high 2*WIDTH+2 = 18 cycles (WIDTH=8); loopback data correct.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one WIDTH-bit MSB-first transfer in any CPOL/CPHA mode,
// driving one of NSS active-low selects with SCLK half-period of HALF_DIV clk cycles.
module spi_master_param #(
    parameter int WIDTH    = 8,
    parameter int HALF_DIV = 2,
    parameter int NSS      = 1,
    parameter int SEL_W    = 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             start,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [SEL_W-1:0] ss_sel,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             miso,
    output logic             sclk,
    output logic             mosi,
    output logic [NSS-1:0]   ss_l,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * WIDTH + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Active-low select pattern with only the addressed slave pulled low.
    function automatic logic [NSS-1:0] sel_mask(input logic [SEL_W-1:0] sel);
        logic [NSS-1:0] mask;
        for (int i = 0; i < NSS; i++) begin
            if (int'(sel) == i) begin
                mask[i] = 1'b0;
            end else begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    logic [1:0]        state_r,    state_s;
    logic [DIV_W-1:0]  div_cnt_r,  div_cnt_s;
    logic [EDGE_W-1:0] edge_cnt_r, edge_cnt_s;
    logic              cpol_r,     cpol_s;
    logic              cpha_r,     cpha_s;
    logic [WIDTH-1:0]  tx_sh_r,    tx_sh_s;
    logic [WIDTH-1:0]  rx_sh_r,    rx_sh_s;
    logic              sclk_r,     sclk_s;
    logic              mosi_r,     mosi_s;
    logic [NSS-1:0]    ss_l_r,     ss_l_s;
    logic              busy_r,     busy_s;
    logic              done_r,     done_s;
    logic [WIDTH-1:0]  rx_data_r,  rx_data_s;

    logic div_wrap_s;
    logic sel_ok_s;
    logic lead_s;
    logic sample_s;

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_s    = state_r;
        div_cnt_s  = div_cnt_r;
        edge_cnt_s = edge_cnt_r;
        cpol_s     = cpol_r;
        cpha_s     = cpha_r;
        tx_sh_s    = tx_sh_r;
        rx_sh_s    = rx_sh_r;
        sclk_s     = sclk_r;
        mosi_s     = mosi_r;
        ss_l_s     = ss_l_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        rx_data_s  = rx_data_r;
        div_wrap_s = (div_cnt_r == DIV_LAST);
        sel_ok_s   = (int'(ss_sel) < NSS);
        // edge_cnt_r counts completed edges, so an even count means the coming edge is odd (leading)
        lead_s     = ~edge_cnt_r[0];
        sample_s   = lead_s ^ cpha_r;

        case (state_r)
            ST_IDLE: begin
                if (start && sel_ok_s) begin
                    state_s    = ST_SETUP;
                    div_cnt_s  = '0;
                    edge_cnt_s = '0;
                    cpol_s     = cpol;
                    cpha_s     = cpha;
                    sclk_s     = cpol;
                    ss_l_s     = sel_mask(ss_sel);
                    busy_s     = 1'b1;
                    rx_sh_s    = '0;
                    if (!cpha) begin
                        mosi_s  = tx_data[WIDTH-1];
                        tx_sh_s = {tx_data[WIDTH-2:0], 1'b0};
                    end else begin
                        tx_sh_s = tx_data;
                    end
                end else begin
                    sclk_s = cpol_r;
                end
            end
            ST_SETUP: begin
                if (div_wrap_s) begin
                    state_s    = ST_SHIFT;
                    div_cnt_s  = '0;
                    edge_cnt_s = '0;
                end else begin
                    div_cnt_s = div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SHIFT: begin
                if (div_wrap_s) begin
                    div_cnt_s  = '0;
                    sclk_s     = ~sclk_r;
                    edge_cnt_s = edge_cnt_r + {{(EDGE_W-1){1'b0}}, 1'b1};
                    if (sample_s) begin
                        rx_sh_s = {rx_sh_r[WIDTH-2:0], miso};
                    end else if (edge_cnt_r != EDGE_LAST) begin
                        mosi_s  = tx_sh_r[WIDTH-1];
                        tx_sh_s = {tx_sh_r[WIDTH-2:0], 1'b0};
                    end else begin
                        mosi_s = mosi_r;
                    end
                    if (edge_cnt_r == EDGE_LAST) begin
                        state_s    = ST_HOLD;
                        edge_cnt_s = '0;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    div_cnt_s = div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (div_wrap_s) begin
                    state_s    = ST_IDLE;
                    div_cnt_s  = '0;
                    edge_cnt_s = '0;
                    ss_l_s     = '1;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    rx_data_s  = rx_sh_r;
                end else begin
                    div_cnt_s = div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s    = ST_IDLE;
                div_cnt_s  = '0;
                edge_cnt_s = '0;
                ss_l_s     = '1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= '0;
            edge_cnt_r <= '0;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            tx_sh_r    <= '0;
            rx_sh_r    <= '0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            ss_l_r     <= '1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rx_data_r  <= '0;
        end else begin
            state_r    <= state_s;
            div_cnt_r  <= div_cnt_s;
            edge_cnt_r <= edge_cnt_s;
            cpol_r     <= cpol_s;
            cpha_r     <= cpha_s;
            tx_sh_r    <= tx_sh_s;
            rx_sh_r    <= rx_sh_s;
            sclk_r     <= sclk_s;
            mosi_r     <= mosi_s;
            ss_l_r     <= ss_l_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            rx_data_r  <= rx_data_s;
        end
    end

    assign sclk    = sclk_r;
    assign mosi    = mosi_r;
    assign ss_l    = ss_l_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: two instances (8-bit/HALF_DIV=2/1 select and
// 16-bit/HALF_DIV=1/4 selects) checked against a behavioural SPI slave and timing formulas.
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l, start_a, start_b, cpol, cpha, miso, s_miso, loop, use_b;
    logic [2:0]  ss_sel;
    logic [15:0] tx;

    logic        a_sclk, a_mosi, a_busy, a_done;
    logic [0:0]  a_ss_l;
    logic [7:0]  a_rx;
    logic        b_sclk, b_mosi, b_busy, b_done;
    logic [3:0]  b_ss_l;
    logic [15:0] b_rx;

    logic        m_sclk, m_mosi, m_busy, m_done;
    logic [3:0]  m_ss_l;
    logic [15:0] m_rx;

    assign m_sclk = use_b ? b_sclk : a_sclk;
    assign m_mosi = use_b ? b_mosi : a_mosi;
    assign m_busy = use_b ? b_busy : a_busy;
    assign m_done = use_b ? b_done : a_done;
    assign m_ss_l = use_b ? b_ss_l : {3'b111, a_ss_l};
    assign m_rx   = use_b ? b_rx : {8'h00, a_rx};
    assign miso   = loop ? m_mosi : s_miso;

    spi_master_param #(.WIDTH(8), .HALF_DIV(2), .NSS(1), .SEL_W(1)) dut_a (
        .clk(clk), .rst_l(rst_l), .start(start_a), .cpol(cpol), .cpha(cpha),
        .ss_sel(ss_sel[0:0]), .tx_data(tx[7:0]), .miso(miso),
        .sclk(a_sclk), .mosi(a_mosi), .ss_l(a_ss_l), .busy(a_busy), .done(a_done), .rx_data(a_rx)
    );

    spi_master_param #(.WIDTH(16), .HALF_DIV(1), .NSS(4), .SEL_W(3)) dut_b (
        .clk(clk), .rst_l(rst_l), .start(start_b), .cpol(cpol), .cpha(cpha),
        .ss_sel(ss_sel), .tx_data(tx), .miso(miso),
        .sclk(b_sclk), .mosi(b_mosi), .ss_l(b_ss_l), .busy(b_busy), .done(b_done), .rx_data(b_rx)
    );

    int compared = 0;
    int mismatched = 0;
    int busy_cnt, done_cnt, ss_cnt, edge_cnt, mosi_bad, ss_bad, gap_bad;
    int since_edge, s_nedge, ss_gap, last_gap, cur_w, cur_h;
    logic        prev_sclk, prev_mosi, prev_ss, cpha_t;
    logic [15:0] s_word, s_in;
    logic [3:0]  exp_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; ss_cnt = 0; edge_cnt = 0;
        mosi_bad = 0; ss_bad = 0; gap_bad = 0;
    endtask

    // One clk cycle: observe at negedge and act as the SPI slave for the selected instance.
    task automatic step();
        logic ss_now, lead, shift_edge;
        int k;
        @(negedge clk);
        ss_now = (m_ss_l != 4'hF);
        if (m_busy) busy_cnt++;
        if (m_done) done_cnt++;
        since_edge++;
        if (ss_now) begin
            ss_cnt++;
            if (m_ss_l != exp_mask) ss_bad++;
            if (!prev_ss) begin
                last_gap   = ss_gap;
                since_edge = 0;
                s_nedge    = 0;
                s_in       = 16'h0000;
                if (!cpha_t) s_miso = s_word[cur_w-1];
            end else if (m_sclk != prev_sclk) begin
                s_nedge++;
                edge_cnt++;
                if (since_edge != ((s_nedge == 1) ? 2 * cur_h : cur_h)) gap_bad++;
                since_edge = 0;
                lead       = (s_nedge % 2) == 1;
                shift_edge = (lead == cpha_t);
                if (!shift_edge) begin
                    s_in = {s_in[14:0], m_mosi};
                    if (m_mosi != prev_mosi) mosi_bad++;
                end else begin
                    k = cpha_t ? (cur_w - 1 - (s_nedge - 1) / 2) : (cur_w - 1 - s_nedge / 2);
                    if (k >= 0) s_miso = s_word[k];
                end
            end else if (m_mosi != prev_mosi) begin
                mosi_bad++;
            end
        end else begin
            if (prev_ss && since_edge != cur_h) gap_bad++;
            ss_gap = prev_ss ? 1 : ss_gap + 1;
        end
        prev_ss   = ss_now;
        prev_sclk = m_sclk;
        prev_mosi = m_mosi;
    endtask

    task automatic setup(input logic b, input logic cp, input logic ch, input logic [2:0] sel,
                         input logic [15:0] txw, input logic [15:0] sw, input logic lp);
        use_b  = b;
        cur_w  = b ? 16 : 8;
        cur_h  = b ? 1 : 2;
        cpol   = cp;
        cpha   = ch;
        cpha_t = ch;
        ss_sel = sel;
        tx     = b ? txw : {8'h00, txw[7:0]};
        s_word = b ? sw : {8'h00, sw[7:0]};
        loop   = lp;
        exp_mask = 4'hF;
        if (int'(sel) < (b ? 4 : 1)) exp_mask[sel[1:0]] = 1'b0;
        clear_counts();
    endtask

    task automatic run_xfer(input logic b, input logic cp, input logic ch, input logic [2:0] sel,
                            input logic [15:0] txw, input logic [15:0] sw, input logic lp,
                            input string tag);
        int bound;
        logic acc;
        logic [15:0] exp_rx, exp_tx;
        setup(b, cp, ch, sel, txw, sw, lp);
        acc    = int'(sel) < (b ? 4 : 1);
        exp_tx = tx;
        exp_rx = lp ? tx : s_word;
        bound  = cur_h * (2 * cur_w + 2) + 8;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        // scramble the request inputs mid-transfer; they must not matter until the next start
        tx     = 16'($urandom);
        cpol   = 1'($urandom);
        cpha   = 1'($urandom);
        ss_sel = 3'($urandom);
        if (acc) begin
            for (int i = 0; i < bound && !m_done; i++) step();
            chk({tag, "_done_seen"}, 32'(m_done), 32'd1);
            chk({tag, "_busy_len"}, busy_cnt, cur_h * (2 * cur_w + 2));
            chk({tag, "_ss_len"}, ss_cnt, cur_h * (2 * cur_w + 2));
            chk({tag, "_edges"}, edge_cnt, 2 * cur_w);
            chk({tag, "_rx"}, 32'(m_rx), 32'(exp_rx));
            chk({tag, "_slave_rx"}, 32'(s_in), 32'(exp_tx));
            chk({tag, "_sclk_idle"}, 32'(m_sclk), 32'(cp));
            chk({tag, "_timing"}, gap_bad, 0);
            chk({tag, "_mosi_stable"}, mosi_bad, 0);
            chk({tag, "_ss_pattern"}, ss_bad, 0);
            step();
            chk({tag, "_done_once"}, done_cnt, 1);
        end else begin
            for (int i = 0; i < bound; i++) step();
            chk({tag, "_ign_busy"}, busy_cnt, 0);
            chk({tag, "_ign_done"}, done_cnt, 0);
            chk({tag, "_ign_ss"}, ss_cnt, 0);
        end
    endtask

    initial begin
        logic [15:0] tx1, tx2;
        rst_l = 1'b0; start_a = 1'b0; start_b = 1'b0; cpol = 1'b0; cpha = 1'b0;
        ss_sel = 3'd0; tx = 16'h0000; loop = 1'b0; use_b = 1'b0; s_miso = 1'b0;
        cpha_t = 1'b0; s_word = 16'h0000; s_in = 16'h0000; exp_mask = 4'hF;
        cur_w = 8; cur_h = 2; since_edge = 0; s_nedge = 0; ss_gap = 100; last_gap = 0;
        prev_ss = 1'b0; prev_sclk = 1'b0; prev_mosi = 1'b0;
        clear_counts();
        step(); step();
        rst_l = 1'b1;
        chk("rst_a_sclk", 32'(a_sclk), 32'd0);
        chk("rst_a_mosi", 32'(a_mosi), 32'd0);
        chk("rst_a_ss", 32'(a_ss_l), 32'd1);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_done", 32'(a_done), 32'd0);
        chk("rst_a_rx", 32'(a_rx), 32'd0);
        chk("rst_b_ss", 32'(b_ss_l), 32'hF);
        chk("rst_b_rx", 32'(b_rx), 32'd0);
        step();

        run_xfer(1'b0, 1'b0, 1'b0, 3'd0, 16'h00F4, 16'h0000, 1'b1, "mode0_loop");
        run_xfer(1'b0, 1'b1, 1'b1, 3'd0, 16'h003C, 16'h007F, 1'b0, "mode3");
        run_xfer(1'b0, 1'b0, 1'b0, 3'd1, 16'h0055, 16'h0000, 1'b0, "a_bad_sel");
        for (int r = 0; r < 6; r++) begin
            run_xfer(1'b0, 1'($urandom), 1'($urandom), 3'd0, 16'($urandom), 16'($urandom),
                     1'($urandom), "a_rand");
        end

        // Handshake: ignored mid-transfer start, then start held across done.
        tx1 = 16'($urandom_range(1, 255));
        tx2 = 16'($urandom_range(1, 255));
        setup(1'b0, 1'b0, 1'b0, 3'd0, tx1, 16'h0000, 1'b1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (10) step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        tx = tx2;
        repeat (5) step();
        start_a = 1'b1;
        for (int i = 0; i < 60 && !m_done; i++) step();
        chk("hs_first_done", 32'(m_done), 32'd1);
        chk("hs_first_rx", 32'(m_rx), 32'(tx1));
        step();
        start_a = 1'b0;
        chk("hs_second_busy", 32'(m_busy), 32'd1);
        chk("hs_gap", last_gap, 1);
        for (int i = 0; i < 60 && !m_done; i++) step();
        chk("hs_second_rx", 32'(m_rx), 32'(tx2));
        step();
        chk("hs_done_total", done_cnt, 2);
        chk("hs_busy_total", busy_cnt, 72);

        // Reset abort at edge 7.
        setup(1'b0, 1'b1, 1'b0, 3'd0, 16'h00A6, 16'h0000, 1'b1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 60 && edge_cnt < 7; i++) step();
        chk("abort_edge7", edge_cnt, 7);
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        chk("abort_ss", 32'(a_ss_l), 32'd1);
        chk("abort_sclk", 32'(a_sclk), 32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_rx", 32'(a_rx), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        repeat (4) step();
        chk("abort_no_done", done_cnt, 0);
        run_xfer(1'b0, 1'b0, 1'b1, 3'd0, 16'h0093, 16'h005A, 1'b0, "after_abort");

        run_xfer(1'b1, 1'b0, 1'b0, 3'd2, 16'hA5C3, 16'h1234, 1'b0, "multi_sel2");
        run_xfer(1'b1, 1'b0, 1'b0, 3'd5, 16'hA5C3, 16'h1234, 1'b0, "b_bad_sel");
        for (int r = 0; r < 5; r++) begin
            run_xfer(1'b1, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
                     16'($urandom), 16'($urandom), 1'($urandom), "b_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
